// File: rtl/load_store_unit.sv
// Load/store unit: turns one CPU load/store into one or two aligned, byte-enabled
// memory beats, then merges and extends load data into a single response.
module load_store_unit #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_load,
    input  logic [1:0]        req_dw,
    input  logic              req_sign_ex,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_fault,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE0, S_WAIT0, S_ISSUE1, S_WAIT1, S_RESP
    } state_t;

    state_t            r_state, w_next;
    logic              r_load;
    logic [1:0]        r_dw;
    logic              r_sign_ex;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rdata0;
    logic [31:0]       r_rdata1;

    logic [1:0]        w_off;
    logic [2:0]        w_nbytes;
    logic [3:0]        w_mask;
    logic              w_split;
    logic              w_fault;
    logic [7:0]        w_be_wide;
    logic [63:0]       w_wd_wide;
    logic [31:0]       w_merged;
    logic [31:0]       w_load_data;
    logic [ADDR_W-1:0] w_word0;
    logic [ADDR_W-1:0] w_word1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_load    <= 1'b0;
            r_dw      <= '0;
            r_sign_ex <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rdata0  <= '0;
            r_rdata1  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && req_valid) begin
                r_load    <= req_load;
                r_dw      <= req_dw;
                r_sign_ex <= req_sign_ex;
                r_addr    <= req_addr;
                r_wdata   <= req_wdata;
                r_rdata0  <= '0;
                r_rdata1  <= '0;
            end
            if (r_state == S_WAIT0 && mem_rvalid) r_rdata0 <= mem_rdata;
            if (r_state == S_WAIT1 && mem_rvalid) r_rdata1 <= mem_rdata;
        end
    end

    always_comb begin
        w_nbytes = 3'd4;
        w_mask   = 4'b1111;
        case (r_dw)
            2'd0:    begin w_nbytes = 3'd1; w_mask = 4'b0001; end
            2'd1:    begin w_nbytes = 3'd2; w_mask = 4'b0011; end
            default: begin w_nbytes = 3'd4; w_mask = 4'b1111; end
        endcase
    end

    assign w_off     = r_addr[1:0];
    assign w_split   = ({1'b0, w_off} + w_nbytes) > 3'd4;
    assign w_fault   = (r_dw == 2'd3);
    // Upper halves of the widened shifts are the second-beat lanes of a split access.
    assign w_be_wide = {4'b0000, w_mask} << w_off;
    assign w_wd_wide = {32'b0, r_wdata} << {w_off, 3'b000};
    assign w_merged  = 32'({r_rdata1, r_rdata0} >> {w_off, 3'b000});
    assign w_word0   = {r_addr[ADDR_W-1:2], 2'b00};
    assign w_word1   = w_word0 + ADDR_W'(4);

    always_comb begin
        w_load_data = w_merged;
        case (r_dw)
            2'd0:    w_load_data = {{24{r_sign_ex & w_merged[7]}}, w_merged[7:0]};
            2'd1:    w_load_data = {{16{r_sign_ex & w_merged[15]}}, w_merged[15:0]};
            default: w_load_data = w_merged;
        endcase
    end

    always_comb begin
        w_next    = r_state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_fault = 1'b0;
        rsp_rdata = '0;
        mem_valid = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_be    = '0;
        mem_wdata = '0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) w_next = (req_dw == 2'd3) ? S_RESP : S_ISSUE0;
            end
            S_ISSUE0: begin
                mem_valid = 1'b1;
                mem_we    = !r_load;
                mem_addr  = w_word0;
                mem_be    = w_be_wide[3:0];
                mem_wdata = w_wd_wide[31:0];
                if (mem_ready) w_next = S_WAIT0;
            end
            S_WAIT0: begin
                if (mem_rvalid) w_next = w_split ? S_ISSUE1 : S_RESP;
            end
            S_ISSUE1: begin
                mem_valid = 1'b1;
                mem_we    = !r_load;
                mem_addr  = w_word1;
                mem_be    = w_be_wide[7:4];
                mem_wdata = w_wd_wide[63:32];
                if (mem_ready) w_next = S_WAIT1;
            end
            S_WAIT1: begin
                if (mem_rvalid) w_next = S_RESP;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                rsp_fault = w_fault;
                if (r_load && !w_fault) rsp_rdata = w_load_data;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a scripted memory responder records every
// beat, and each op's beats, latency and response are checked against hand values.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_load, req_sign_ex;
    logic [1:0]  req_dw;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_fault;
    logic [31:0] rsp_rdata;
    logic        mem_valid, mem_ready, mem_we, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    logic [31:0] b_addr [2];
    logic [31:0] b_wdata[2];
    logic [3:0]  b_be   [2];
    logic        b_we   [2];
    int          nb, lat;
    logic [31:0] got_data;
    logic        got_fault;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_load(req_load),
        .req_dw(req_dw), .req_sign_ex(req_sign_ex), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    task automatic check_val(input string tag, input logic [71:0] act, input logic [71:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Runs one op; the responder returns rd0/rd1 one cycle after each beat handshake
    // and holds mem_ready low for 'stall' cycles on the first beat.
    task automatic run_op(input logic ld, input logic [1:0] dw, input logic sx,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rd0, input logic [31:0] rd1, input int stall);
        int          cyc;
        logic        pend, done, have_snap;
        logic [68:0] snap;
        nb = 0; lat = 0; got_data = '0; got_fault = 1'b0;
        pend = 1'b0; done = 1'b0; have_snap = 1'b0; snap = '0;
        for (int i = 0; i < 2; i++) begin
            b_addr[i] = '0; b_wdata[i] = '0; b_be[i] = '0; b_we[i] = 1'b0;
        end
        @(negedge clk);
        check_val("req_ready_idle", 72'(req_ready), 72'(1));
        req_valid = 1'b1; req_load = ld; req_dw = dw; req_sign_ex = sx;
        req_addr = addr; req_wdata = wdata; mem_ready = 1'b1; mem_rvalid = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        cyc = 1;
        while (!done && cyc <= 40) begin
            mem_rvalid = 1'b0;
            if (rsp_valid) begin
                lat = cyc; got_data = rsp_rdata; got_fault = rsp_fault; done = 1'b1;
            end else begin
                check_val("req_ready_busy", 72'(req_ready), 72'(0));
                if (pend) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = (nb == 1) ? rd0 : rd1;
                    pend = 1'b0;
                end
                if (mem_valid) begin
                    if (have_snap)
                        check_val("hold_stable", 72'({mem_we, mem_be, mem_addr, mem_wdata}), 72'(snap));
                    if (stall > 0) begin
                        snap = {mem_we, mem_be, mem_addr, mem_wdata};
                        have_snap = 1'b1;
                        mem_ready = 1'b0;
                        stall--;
                    end else begin
                        if (nb < 2) begin
                            b_addr[nb] = mem_addr; b_wdata[nb] = mem_wdata;
                            b_be[nb] = mem_be; b_we[nb] = mem_we;
                        end
                        nb++;
                        have_snap = 1'b0;
                        mem_ready = 1'b1;
                        pend = 1'b1;
                    end
                end
                @(negedge clk);
                cyc++;
            end
        end
        if (!done) check_val("rsp_timeout", 72'(0), 72'(1));
        mem_rvalid = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        check_val("rsp_one_cycle", 72'(rsp_valid), 72'(0));
    endtask

    initial begin
        int stray;
        rst_n = 1'b0; req_valid = 1'b0; req_load = 1'b0; req_dw = '0; req_sign_ex = 1'b0;
        req_addr = '0; req_wdata = '0; mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        #12;
        check_val("rst_req_ready", 72'(req_ready), 72'(1));
        check_val("rst_flags", 72'({rsp_valid, rsp_fault, mem_valid, mem_we}), 72'(0));
        check_val("rst_mem_addr", 72'(mem_addr), 72'(0));
        check_val("rst_be_wdata", 72'({mem_be, mem_wdata}), 72'(0));
        check_val("rst_rdata", 72'(rsp_rdata), 72'(0));
        rst_n = 1'b1;

        // Aligned word load
        run_op(1'b1, 2'd2, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 32'h0, 0);
        check_val("wl_nbeats", 72'(nb), 72'(1));
        check_val("wl_beat0", 72'({b_we[0], b_be[0], b_addr[0]}), 72'({1'b0, 4'b1111, 32'h100}));
        check_val("wl_data", 72'({got_fault, got_data}), 72'({1'b0, 32'hDEADBEEF}));
        check_val("wl_latency", 72'(lat), 72'(3));

        // Signed / unsigned byte load in the top lane
        run_op(1'b1, 2'd0, 1'b1, 32'h203, 32'h0, 32'h80FFFFFF, 32'h0, 0);
        check_val("lbs_beat0", 72'({b_be[0], b_addr[0]}), 72'({4'b1000, 32'h200}));
        check_val("lbs_data", 72'(got_data), 72'(32'hFFFFFF80));
        run_op(1'b1, 2'd0, 1'b0, 32'h203, 32'h0, 32'h80FFFFFF, 32'h0, 0);
        check_val("lbu_data", 72'(got_data), 72'(32'h00000080));

        // Half at offset 2 fits in one word; signed
        run_op(1'b1, 2'd1, 1'b1, 32'h302, 32'h0, 32'h80011234, 32'h0, 0);
        check_val("lhs_nbeats", 72'(nb), 72'(1));
        check_val("lhs_be", 72'(b_be[0]), 72'(4'b1100));
        check_val("lhs_data", 72'(got_data), 72'(32'hFFFF8001));

        // Misaligned half store splits
        run_op(1'b0, 2'd1, 1'b0, 32'h107, 32'h0000ABCD, 32'h0, 32'h0, 0);
        check_val("sh_nbeats", 72'(nb), 72'(2));
        check_val("sh_beat0", 72'({b_we[0], b_be[0], b_addr[0], b_wdata[0]}),
                  72'({1'b1, 4'b1000, 32'h104, 32'hCD000000}));
        check_val("sh_beat1", 72'({b_we[1], b_be[1], b_addr[1], b_wdata[1]}),
                  72'({1'b1, 4'b0001, 32'h108, 32'h000000AB}));
        check_val("sh_rsp", 72'({got_fault, got_data}), 72'(0));
        check_val("sh_latency", 72'(lat), 72'(5));

        // Misaligned word load wrapping the address space
        run_op(1'b1, 2'd2, 1'b0, 32'hFFFFFFFE, 32'h0, 32'h3344AAAA, 32'h55551122, 0);
        check_val("wrap_nbeats", 72'(nb), 72'(2));
        check_val("wrap_beat0", 72'({b_be[0], b_addr[0]}), 72'({4'b1100, 32'hFFFFFFFC}));
        check_val("wrap_beat1", 72'({b_be[1], b_addr[1]}), 72'({4'b0011, 32'h00000000}));
        check_val("wrap_data", 72'(got_data), 72'(32'h11223344));

        // Back-pressure on the first beat
        run_op(1'b0, 2'd2, 1'b0, 32'h40, 32'h12345678, 32'h0, 32'h0, 5);
        check_val("bp_beat0", 72'({b_we[0], b_be[0], b_addr[0], b_wdata[0]}),
                  72'({1'b1, 4'b1111, 32'h40, 32'h12345678}));
        check_val("bp_latency", 72'(lat), 72'(8));

        // Illegal width
        run_op(1'b1, 2'd3, 1'b1, 32'h100, 32'h0, 32'hFFFFFFFF, 32'h0, 0);
        check_val("fault_nbeats", 72'(nb), 72'(0));
        check_val("fault_rsp", 72'({got_fault, got_data}), 72'({1'b1, 32'h0}));
        check_val("fault_latency", 72'(lat), 72'(1));

        // Reset during WAIT0, then a stray read return
        @(negedge clk);
        req_valid = 1'b1; req_load = 1'b1; req_dw = 2'd2; req_addr = 32'h500; mem_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        check_val("rw_issue", 72'({mem_valid, mem_addr}), 72'({1'b1, 32'h500}));
        @(negedge clk);
        check_val("rw_wait_ready", 72'(req_ready), 72'(0));
        #2 rst_n = 1'b0;
        #1;
        check_val("rw_req_ready", 72'(req_ready), 72'(1));
        check_val("rw_outputs", 72'({rsp_valid, rsp_fault, mem_valid, mem_we, mem_be, mem_addr}), 72'(0));
        #1 rst_n = 1'b1;
        @(negedge clk);
        mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
        stray = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mem_rvalid = 1'b0;
            if (rsp_valid) stray++;
        end
        check_val("rw_stray_rsp", 72'(stray), 72'(0));
        check_val("rw_idle_ready", 72'(req_ready), 72'(1));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- CPU-side initiator for the data memory port. Accepts one load or store from the execute stage, with byte, half or word width and optional sign extension.
- Converts each access into one or two word-aligned, byte-enabled memory beats using a valid/ready request channel and an in-order read/ack channel.
- Merges and extends load data, then returns a single response to writeback.
- Handles misaligned accesses by splitting them into two beats, so the memory side only ever sees aligned words.

Parameters:
- ADDR_W, 32, byte address width. mem_addr[1:0] is always 0.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  execute-stage op valid
- req_ready  out  1  unit can accept an op
- req_load  in  1  1 = load, 0 = store
- req_dw  in  2  width: 0 = byte (DB), 1 = half (DH), 2 = word (DW), 3 = illegal
- req_sign_ex  in  1  sign-extend the loaded value (loads only)
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-aligned
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  32  extended load data; 0 for stores and faults
- rsp_fault  out  1  illegal width (valid with rsp_valid)
- mem_valid  out  1  memory beat request
- mem_ready  in  1  memory accepts the beat
- mem_we  out  1  1 = write beat
- mem_addr  out  ADDR_W  word-aligned beat address
- mem_be  out  4  byte enables; lane i = bits [8i+7:8i], little endian
- mem_wdata  out  32  lane-positioned store data
- mem_rvalid  in  1  read data or write ack for the oldest accepted beat
- mem_rdata  in  32  read data, valid with mem_rvalid

Behaviour:
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - req_ready = 1; rsp_valid, rsp_fault, mem_valid and mem_we = 0.
  - mem_addr, mem_be, mem_wdata and rsp_rdata = 0.
  - All captured request fields are cleared.
  - An in-flight beat is abandoned, and any later mem_rvalid is ignored until a new beat is issued.
- States: IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1, RESP.
- IDLE:
  - req_ready = 1 only in IDLE.
  - req_valid & req_ready captures all req_* fields.
  - Next state is RESP (fault) if req_dw = 3, otherwise ISSUE0.
- Geometry: o = addr[1:0]; n = 1, 2 or 4 bytes; m = (1<<n)-1. split = (o+n > 4).
- ISSUE0:
  - mem_valid = 1, mem_addr = {addr[ADDR_W-1:2], 2'b00}.
  - mem_be = (m<<o)[3:0], mem_wdata = wdata<<(8*o), mem_we = !load.
  - All mem_* outputs are held stable until mem_ready; the handshake moves to WAIT0.
- WAIT0: mem_valid = 0. On mem_rvalid, capture rdata0 and go to ISSUE1 if split, else RESP.
- ISSUE1:
  - mem_addr = word0 + 4, wrapping modulo 2^ADDR_W (0xFFFFFFFC becomes 0x00000000).
  - mem_be = m>>(4-o), mem_wdata = wdata>>(8*(4-o)).
  - The handshake moves to WAIT1.
- WAIT1: on mem_rvalid, capture rdata1 and go to RESP.
- mem_rvalid in IDLE, ISSUE0, ISSUE1 or RESP is ignored.
- Load merge:
  - v = ({rdata1, rdata0} >> 8*o)[8n-1:0], with rdata1 = 0 if not split.
  - rsp_rdata = v, sign-extended from bit 8n-1 if sign_ex, else zero-extended.
  - Word loads ignore sign_ex.
- RESP:
  - rsp_valid = 1 for exactly one cycle.
  - rsp_fault = 1 only for illegal width, in which case no memory beat was issued and rsp_rdata = 0.
  - Next state is IDLE, so back-to-back ops are separated by at least one IDLE cycle.
- Latency (accept to rsp_valid) with mem_ready = 1 and mem_rvalid one cycle after acceptance:
  - aligned: 3 cycles
  - split: 5 cycles
  - fault: 1 cycle
- Memory stalls (mem_ready = 0, or a delayed mem_rvalid) extend the latency without limit. There is no timeout.
- Stores split exactly like loads and complete on their ack(s).

Test Plan:
- Aligned word load, addr 0x100, mem returns 0xDEADBEEF:
  - one beat: be = 4'b1111, addr 0x100, we = 0
  - rsp_rdata = 0xDEADBEEF, exactly 3 cycles after accept
- Signed byte load, addr 0x203, rdata 0x80FFFFFF:
  - be = 4'b1000
  - sign_ex = 1 gives rsp_rdata = 0xFFFFFF80; sign_ex = 0 gives 0x00000080
- Misaligned half store, addr 0x107, wdata 0x0000ABCD:
  - beat0: addr 0x104, be = 1000, wdata = 0xCD000000
  - beat1: addr 0x108, be = 0001, wdata = 0x000000AB
  - rsp_valid after the second ack
- Misaligned word load, addr 0xFFFFFFFE, rdata0 = 0x3344xxxx, rdata1 = 0xxxxx1122:
  - beat1 addr = 0x00000000 (wrap)
  - rsp_rdata = 0x11223344
- Back-pressure: mem_ready held low for 5 cycles in ISSUE0 -> mem_addr, mem_be, mem_wdata and mem_we remain stable, and req_ready stays 0 throughout.
- Remaining cases:
  - req_dw = 3 -> no mem_valid; rsp_valid and rsp_fault = 1 one cycle later.
  - rst_n pulsed low during WAIT0 -> all outputs return to reset values at once, and a stray mem_rvalid afterwards produces no rsp_valid.
